pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central hazard/sequencing controller for the 5-stage pipeline. Generates stall/flush for PC, IF/ID,
//  ID/EX, EX/MEM and MEM/WB registers from load-use hazards, EX-resolved branches and data-memory waits.
//  Holds multi-cycle state (memory wait, extended redirect flush) and a saturating stall-cycle counter.
// PARAMETERS
//  FLUSH_CYCLES  1   cycles IF/ID is flushed after a taken branch (>1 covers multi-cycle IMEM latency)
//  CNT_W         32  width of stall_cnt performance counter
// PORTS
//  clk              in   1      clock; single clock domain
//  rst_n            in   1      asynchronous active-low reset
//  id_rs1, id_rs2   in   5      source regs of instr in ID
//  id_rs1_used      in   1      ID instr reads rs1
//  id_rs2_used      in   1      ID instr reads rs2
//  ex_rd            in   5      dest reg of instr in EX
//  ex_mem_read      in   1      EX instr is a load
//  ex_branch_taken  in   1      EX resolved taken branch/jump (PC redirect this cycle)
//  dmem_req         in   1      MEM stage has an access in flight
//  dmem_ready       in   1      data memory completes access this cycle
//  pc_stall         out  1      hold PC
//  if_id_stall      out  1      hold IF/ID
//  if_id_flush      out  1      load NOP (32'h0) into IF/ID
//  id_ex_stall      out  1      hold ID/EX
//  id_ex_flush      out  1      bubble into ID/EX
//  ex_mem_stall     out  1      hold EX/MEM
//  mem_wb_flush     out  1      bubble into MEM/WB
//  stall_cnt        out  CNT_W  cycles with pc_stall=1, saturates at all-ones
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=RUN, flush counter=0, stall_cnt=0; with inputs idle all outputs 0.
//  - Outputs are combinational from registered state + current inputs (zero-latency stall/flush);
//    state and counters update on posedge clk.
//  - States: RUN, MEM_WAIT, REDIRECT (enum in package).
//  - Conditions: memwait = dmem_req & ~dmem_ready;
//    loaduse = ex_mem_read & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
//  - Priority (highest first): memwait > ex_branch_taken > REDIRECT state > loaduse > none.
//  - memwait: pc/if_id/id_ex/ex_mem stall=1, mem_wb_flush=1, all other flushes 0; state->MEM_WAIT.
//    Stays while memwait; exit to RUN the cycle dmem_ready=1. Branch in EX is held, acted on after release.
//  - ex_branch_taken (no memwait): if_id_flush=1, id_ex_flush=1, pc_stall=0 (PC loads target).
//    If FLUSH_CYCLES>1: state->REDIRECT, flush counter=FLUSH_CYCLES-1.
//  - REDIRECT: if_id_flush=1 only; counter decrements; ->RUN when counter reaches 1 (last flush cycle).
//    A new taken branch in REDIRECT reloads the counter.
//  - loaduse: pc_stall=1, if_id_stall=1, id_ex_flush=1; exactly one bubble (next cycle load is in MEM).
//  - Stall and flush never both asserted on same register; flush wins if conditions overlap.
//  - x0 never causes a hazard. stall_cnt increments each cycle pc_stall=1, holds at 2^CNT_W-1.
//  - Reset mid-MEM_WAIT/REDIRECT: immediate return to RUN, counters cleared.
// STRUCTURE
//  - common package: hazard_state_e {RUN, MEM_WAIT, REDIRECT}, NOP_INSTR=32'h0, REG_X0=5'd0.
//  - Sub-module load_use_detect (combinational loaduse compare), instantiated once; FSM, flush counter
//    and stall_cnt in top.
// TESTING
//  - ex_mem_read=1, ex_rd=5, id_rs1=5, id_rs1_used=1 -> 1 cycle pc_stall=if_id_stall=id_ex_flush=1, stall_cnt=1.
//  - Same with ex_rd=0 -> no stall; id_rs2=5 but id_rs2_used=0 -> no stall.
//  - ex_branch_taken=1, FLUSH_CYCLES=3 -> cycle0 if_id+id_ex flush, cycles1-2 if_id_flush only, then idle.
//  - dmem_req=1, dmem_ready=0 for 4 cycles with ex_branch_taken=1 -> 4 cycles full stall+mem_wb_flush,
//    then branch flush on release cycle; stall_cnt=4.
//  - Branch and load-use same cycle -> branch flush only, pc_stall=0.
//  - rst_n low in MEM_WAIT (async, mid-cycle) -> outputs 0, stall_cnt=0; CNT_W=4 saturates at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      REDIRECT = 2'd2
   } hazard_state_e;

   localparam logic [31:0] NOP_INSTR = 32'h0;
   localparam logic [4:0]  REG_X0    = 5'd0;

   function automatic logic reg_match(input logic used, input logic [4:0] rs, input logic [4:0] rd);
      return used && (rs == rd);
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller signal bundle: pipeline status in, stall/flush controls out.
interface pipeline_hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       id_rs1;
   logic [4:0]       id_rs2;
   logic             id_rs1_used;
   logic             id_rs2_used;
   logic [4:0]       ex_rd;
   logic             ex_mem_read;
   logic             ex_branch_taken;
   logic             dmem_req;
   logic             dmem_ready;
   logic             pc_stall;
   logic             if_id_stall;
   logic             if_id_flush;
   logic             id_ex_stall;
   logic             id_ex_flush;
   logic             ex_mem_stall;
   logic             mem_wb_flush;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
             ex_branch_taken, dmem_req, dmem_ready,
      input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
             ex_mem_stall, mem_wb_flush, stall_cnt
   );

   modport slave (
      input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
             ex_branch_taken, dmem_req, dmem_ready,
      output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
             ex_mem_stall, mem_wb_flush, stall_cnt
   );
endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use detector: a load in EX whose destination is read by the instruction in ID.
module load_use_detect
   import pipeline_hazard_ctrl_pkg::*;
(
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_rs1_used,
   input  logic       id_rs2_used,
   input  logic [4:0] ex_rd,
   input  logic       ex_mem_read,
   output logic       load_use
);

   // x0 is hard-wired to zero, so writing it never creates a dependency.
   always_comb begin
      load_use = ex_mem_read && (ex_rd != REG_X0) &&
                 (reg_match(id_rs1_used, id_rs1, ex_rd) || reg_match(id_rs2_used, id_rs2, ex_rd));
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: memory waits, branch redirects, load-use.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   pipeline_hazard_ctrl_if.slave hz
);

   localparam int              FC_W      = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [FC_W-1:0] FC_RELOAD = FC_W'(FLUSH_CYCLES - 1);
   localparam bit              MULTI_FLUSH = (FLUSH_CYCLES > 1);

   hazard_state_e    state_q, state_d;
   logic [FC_W-1:0]  flush_cnt_q, flush_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic mem_wait;
   logic load_use;
   logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush;
   logic if_id_stall_raw, id_ex_stall_raw;

   load_use_detect u_load_use_detect (
      .id_rs1      (hz.id_rs1),
      .id_rs2      (hz.id_rs2),
      .id_rs1_used (hz.id_rs1_used),
      .id_rs2_used (hz.id_rs2_used),
      .ex_rd       (hz.ex_rd),
      .ex_mem_read (hz.ex_mem_read),
      .load_use    (load_use)
   );

   assign mem_wait = hz.dmem_req && !hz.dmem_ready;

   always_comb begin
      state_d         = state_q;
      flush_cnt_d     = flush_cnt_q;
      pc_stall        = 1'b0;
      if_id_stall_raw = 1'b0;
      if_id_flush     = 1'b0;
      id_ex_stall_raw = 1'b0;
      id_ex_flush     = 1'b0;
      ex_mem_stall    = 1'b0;
      mem_wb_flush    = 1'b0;

      if (mem_wait) begin
         // A branch sitting in EX is frozen along with everything else and acted on after release.
         pc_stall        = 1'b1;
         if_id_stall_raw = 1'b1;
         id_ex_stall_raw = 1'b1;
         ex_mem_stall    = 1'b1;
         mem_wb_flush    = 1'b1;
         state_d         = MEM_WAIT;
      end else if (hz.ex_branch_taken) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
         if (MULTI_FLUSH) begin
            state_d     = REDIRECT;
            flush_cnt_d = FC_RELOAD;
         end else begin
            state_d     = RUN;
         end
      end else if (state_q == REDIRECT) begin
         if_id_flush = 1'b1;
         flush_cnt_d = flush_cnt_q - FC_W'(1);
         if (flush_cnt_q == FC_W'(1)) begin
            state_d = RUN;
         end
      end else if (load_use) begin
         pc_stall        = 1'b1;
         if_id_stall_raw = 1'b1;
         id_ex_flush     = 1'b1;
         state_d         = RUN;
      end else begin
         state_d = RUN;
      end
   end

   // A register is never told to hold and to clear in the same cycle; clearing takes precedence.
   assign if_id_stall = if_id_stall_raw && !if_id_flush;
   assign id_ex_stall = id_ex_stall_raw && !id_ex_flush;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (pc_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         flush_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign hz.pc_stall     = pc_stall;
   assign hz.if_id_stall  = if_id_stall;
   assign hz.if_id_flush  = if_id_flush;
   assign hz.id_ex_stall  = id_ex_stall;
   assign hz.id_ex_flush  = id_ex_flush;
   assign hz.ex_mem_stall = ex_mem_stall;
   assign hz.mem_wb_flush = mem_wb_flush;
   assign hz.stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: FLUSH_CYCLES=3/CNT_W=4 main DUT plus a default-parameter DUT.
module tb_pipeline_hazard_ctrl;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   pipeline_hazard_ctrl_if #(.CNT_W(4))  hz0 ();
   pipeline_hazard_ctrl_if #(.CNT_W(32)) hz1 ();

   pipeline_hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(4)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hz0)
   );

   pipeline_hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(32)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hz1)
   );

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic [4:0] rd;
      logic       mr;
      logic       br;
      logic       req;
      logic       rdy;
   } stim_t;

   typedef struct packed {
      logic [6:0] o0;
      logic [6:0] o1;
      logic [3:0] cnt;
   } exp_t;

   // Output vector order: pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush
   localparam logic [6:0] O_NONE = 7'b0000000;
   localparam logic [6:0] O_LU   = 7'b1100100;
   localparam logic [6:0] O_BR   = 7'b0010100;
   localparam logic [6:0] O_RD   = 7'b0010000;
   localparam logic [6:0] O_MW   = 7'b1101011;

   exp_t       sb[$];
   int         n_cmp = 0;
   int         n_bad = 0;
   logic [3:0] exp_cnt = 4'd0;

   function automatic stim_t mk(input int rs1, input int rs2, input bit u1, input bit u2, input int rd,
                                input bit mr, input bit br, input bit req, input bit rdy);
      stim_t s;
      s.rs1 = 5'(rs1); s.rs2 = 5'(rs2); s.u1 = u1; s.u2 = u2; s.rd = 5'(rd);
      s.mr = mr; s.br = br; s.req = req; s.rdy = rdy;
      return s;
   endfunction

   stim_t IDLE, LU1, LU_X0, LU_RS2_UNUSED, LU_RS2, NOT_LOAD, BR, BR_LU, MW, MW_BR, REL, REL_BR, REL_LU;

   function automatic logic [6:0] obs0();
      return {hz0.pc_stall, hz0.if_id_stall, hz0.if_id_flush, hz0.id_ex_stall,
              hz0.id_ex_flush, hz0.ex_mem_stall, hz0.mem_wb_flush};
   endfunction

   function automatic logic [6:0] obs1();
      return {hz1.pc_stall, hz1.if_id_stall, hz1.if_id_flush, hz1.id_ex_stall,
              hz1.id_ex_flush, hz1.ex_mem_stall, hz1.mem_wb_flush};
   endfunction

   task automatic drive(input stim_t s);
      hz0.id_rs1 = s.rs1; hz0.id_rs2 = s.rs2; hz0.id_rs1_used = s.u1; hz0.id_rs2_used = s.u2;
      hz0.ex_rd = s.rd; hz0.ex_mem_read = s.mr; hz0.ex_branch_taken = s.br;
      hz0.dmem_req = s.req; hz0.dmem_ready = s.rdy;
      hz1.id_rs1 = s.rs1; hz1.id_rs2 = s.rs2; hz1.id_rs1_used = s.u1; hz1.id_rs2_used = s.u2;
      hz1.ex_rd = s.rd; hz1.ex_mem_read = s.mr; hz1.ex_branch_taken = s.br;
      hz1.dmem_req = s.req; hz1.dmem_ready = s.rdy;
   endtask

   // One clock of stimulus; the expectation is queued and the counter model advanced.
   task automatic cycle(input stim_t s, input logic [6:0] e0, input logic [6:0] e1);
      exp_t e;
      @(posedge clk);
      #1;
      drive(s);
      e.o0 = e0; e.o1 = e1; e.cnt = exp_cnt;
      sb.push_back(e);
      if (e0[6] && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
      @(negedge clk);
   endtask

   task automatic apply_reset();
      drive(IDLE);
      #1 rst_n = 1'b0;
      exp_cnt = 4'd0;
      sb.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      drive(IDLE);
      #1 rst_n = 1'b0;
      #2;
      n_cmp++;
      if (obs0() !== O_NONE) begin
         n_bad++; $display("FAIL reset_out0 got %b want %b", obs0(), O_NONE);
      end
      n_cmp++;
      if (hz0.stall_cnt !== 4'd0) begin
         n_bad++; $display("FAIL reset_cnt0 got %0d want 0", hz0.stall_cnt);
      end
      n_cmp++;
      if (obs1() !== O_NONE || hz1.stall_cnt !== 32'd0) begin
         n_bad++; $display("FAIL reset_dut1 got %b/%0d want %b/0", obs1(), hz1.stall_cnt, O_NONE);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_load_use();
      stim_t      st[7];
      logic [6:0] ex[7];
      exp_t       e;
      st = '{LU1, IDLE, LU_X0, LU_RS2_UNUSED, LU_RS2, NOT_LOAD, IDLE};
      ex = '{O_LU, O_NONE, O_NONE, O_NONE, O_LU, O_NONE, O_NONE};
      apply_reset();
      for (int i = 0; i < 7; i++) begin
         cycle(st[i], ex[i], ex[i]);
         e = sb.pop_front();
         n_cmp++;
         if (obs0() !== e.o0) begin
            n_bad++; $display("FAIL load_use_out[%0d] got %b want %b", i, obs0(), e.o0);
         end
         n_cmp++;
         if (hz0.stall_cnt !== e.cnt) begin
            n_bad++; $display("FAIL load_use_cnt[%0d] got %0d want %0d", i, hz0.stall_cnt, e.cnt);
         end
      end
   endtask

   task automatic test_branch();
      stim_t      st[10];
      logic [6:0] ex0[10];
      logic [6:0] ex1[10];
      exp_t       e;
      st  = '{BR, IDLE, IDLE, IDLE, BR, IDLE, BR, IDLE, IDLE, IDLE};
      ex0 = '{O_BR, O_RD, O_RD, O_NONE, O_BR, O_RD, O_BR, O_RD, O_RD, O_NONE};
      ex1 = '{O_BR, O_NONE, O_NONE, O_NONE, O_BR, O_NONE, O_BR, O_NONE, O_NONE, O_NONE};
      apply_reset();
      for (int i = 0; i < 10; i++) begin
         cycle(st[i], ex0[i], ex1[i]);
         e = sb.pop_front();
         n_cmp++;
         if (obs0() !== e.o0) begin
            n_bad++; $display("FAIL branch_out3[%0d] got %b want %b", i, obs0(), e.o0);
         end
         n_cmp++;
         if (obs1() !== e.o1) begin
            n_bad++; $display("FAIL branch_out1[%0d] got %b want %b", i, obs1(), e.o1);
         end
      end
      n_cmp++;
      if (hz0.stall_cnt !== 4'd0) begin
         n_bad++; $display("FAIL branch_cnt got %0d want 0", hz0.stall_cnt);
      end
   endtask

   task automatic test_mem_wait();
      stim_t      st[11];
      logic [6:0] ex[11];
      exp_t       e;
      st = '{MW_BR, MW_BR, MW_BR, MW_BR, REL_BR, IDLE, IDLE, IDLE, BR, MW, REL};
      ex = '{O_MW, O_MW, O_MW, O_MW, O_BR, O_RD, O_RD, O_NONE, O_BR, O_MW, O_NONE};
      apply_reset();
      for (int i = 0; i < 11; i++) begin
         cycle(st[i], ex[i], ex[i]);
         e = sb.pop_front();
         n_cmp++;
         if (obs0() !== e.o0) begin
            n_bad++; $display("FAIL mem_wait_out[%0d] got %b want %b", i, obs0(), e.o0);
         end
         n_cmp++;
         if (hz0.stall_cnt !== e.cnt) begin
            n_bad++; $display("FAIL mem_wait_cnt[%0d] got %0d want %0d", i, hz0.stall_cnt, e.cnt);
         end
      end
   endtask

   task automatic test_branch_vs_loaduse();
      stim_t      st[5];
      logic [6:0] ex[5];
      exp_t       e;
      st = '{BR_LU, LU1, LU1, LU1, IDLE};
      ex = '{O_BR, O_RD, O_RD, O_LU, O_NONE};
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         cycle(st[i], ex[i], ex[i]);
         e = sb.pop_front();
         n_cmp++;
         if (obs0() !== e.o0) begin
            n_bad++; $display("FAIL br_vs_lu_out[%0d] got %b want %b", i, obs0(), e.o0);
         end
         n_cmp++;
         if (hz0.stall_cnt !== e.cnt) begin
            n_bad++; $display("FAIL br_vs_lu_cnt[%0d] got %0d want %0d", i, hz0.stall_cnt, e.cnt);
         end
      end
   endtask

   task automatic test_back_to_back();
      stim_t      st[6];
      logic [6:0] ex[6];
      exp_t       e;
      st = '{LU1, LU1, BR, MW, REL_LU, IDLE};
      ex = '{O_LU, O_LU, O_BR, O_MW, O_LU, O_NONE};
      apply_reset();
      for (int i = 0; i < 6; i++) begin
         cycle(st[i], ex[i], ex[i]);
         e = sb.pop_front();
         n_cmp++;
         if (obs0() !== e.o0) begin
            n_bad++; $display("FAIL b2b_out[%0d] got %b want %b", i, obs0(), e.o0);
         end
         n_cmp++;
         if (hz0.stall_cnt !== e.cnt) begin
            n_bad++; $display("FAIL b2b_cnt[%0d] got %0d want %0d", i, hz0.stall_cnt, e.cnt);
         end
      end
   endtask

   task automatic test_async_reset();
      exp_t e;
      apply_reset();
      for (int i = 0; i < 2; i++) begin
         cycle(MW, O_MW, O_MW);
         e = sb.pop_front();
         n_cmp++;
         if (obs0() !== e.o0) begin
            n_bad++; $display("FAIL areset_mw_out[%0d] got %b want %b", i, obs0(), e.o0);
         end
      end
      // Reset lands mid-cycle, well away from any clock edge.
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      drive(IDLE);
      #1;
      n_cmp++;
      if (obs0() !== O_NONE) begin
         n_bad++; $display("FAIL areset_mw_outs got %b want %b", obs0(), O_NONE);
      end
      n_cmp++;
      if (hz0.stall_cnt !== 4'd0) begin
         n_bad++; $display("FAIL areset_mw_cnt got %0d want 0", hz0.stall_cnt);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      exp_cnt = 4'd0;
      @(negedge clk);
      cycle(BR, O_BR, O_BR);
      e = sb.pop_front();
      n_cmp++;
      if (obs0() !== e.o0) begin
         n_bad++; $display("FAIL areset_br_out got %b want %b", obs0(), e.o0);
      end
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      drive(IDLE);
      #1;
      n_cmp++;
      if (obs0() !== O_NONE) begin
         n_bad++; $display("FAIL areset_redirect_outs got %b want %b", obs0(), O_NONE);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      cycle(IDLE, O_NONE, O_NONE);
      e = sb.pop_front();
      n_cmp++;
      if (obs0() !== e.o0 || hz0.stall_cnt !== e.cnt) begin
         n_bad++; $display("FAIL areset_after got %b/%0d want %b/%0d", obs0(), hz0.stall_cnt, e.o0, e.cnt);
      end
   endtask

   task automatic test_saturation();
      exp_t e;
      apply_reset();
      for (int i = 0; i < 22; i++) begin
         if (i < 20) cycle(MW, O_MW, O_MW);
         else if (i == 20) cycle(REL, O_NONE, O_NONE);
         else cycle(IDLE, O_NONE, O_NONE);
         e = sb.pop_front();
         n_cmp++;
         if (obs0() !== e.o0) begin
            n_bad++; $display("FAIL sat_out[%0d] got %b want %b", i, obs0(), e.o0);
         end
         n_cmp++;
         if (hz0.stall_cnt !== e.cnt) begin
            n_bad++; $display("FAIL sat_cnt[%0d] got %0d want %0d", i, hz0.stall_cnt, e.cnt);
         end
      end
      n_cmp++;
      if (hz0.stall_cnt !== 4'd15) begin
         n_bad++; $display("FAIL sat_final got %0d want 15", hz0.stall_cnt);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      IDLE          = '0;
      LU1           = mk(5, 0, 1, 0, 5, 1, 0, 0, 0);
      LU_X0         = mk(0, 0, 1, 0, 0, 1, 0, 0, 0);
      LU_RS2_UNUSED = mk(3, 5, 1, 0, 5, 1, 0, 0, 0);
      LU_RS2        = mk(3, 5, 0, 1, 5, 1, 0, 0, 0);
      NOT_LOAD      = mk(5, 0, 1, 0, 5, 0, 0, 0, 0);
      BR            = mk(0, 0, 0, 0, 0, 0, 1, 0, 0);
      BR_LU         = mk(5, 0, 1, 0, 5, 1, 1, 0, 0);
      MW            = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
      MW_BR         = mk(0, 0, 0, 0, 0, 0, 1, 1, 0);
      REL           = mk(0, 0, 0, 0, 0, 0, 0, 1, 1);
      REL_BR        = mk(0, 0, 0, 0, 0, 0, 1, 1, 1);
      REL_LU        = mk(5, 0, 1, 0, 5, 1, 0, 1, 1);

      test_reset();
      test_load_use();
      test_branch();
      test_mem_wait();
      test_branch_vs_loaduse();
      test_back_to_back();
      test_async_reset();
      test_saturation();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
